// File: rtl/dct_butterfly_stage.sv
// dct_butterfly_stage
//   Two-stage valid/ready butterfly stage for the JPEG DCT datapath. Each beat carries LANES
//   independent signed (a, b) pairs. Stage 1 captures the beat and its mode. Stage 2 computes
//   pass, butterfly, scaled butterfly or swap and registers the result. An output block counter
//   flags the last beat of every BLOCK_LEN-beat row.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   blk_clr_i    synchronous flush of both pipeline stages and the block counter
//   mode_i       00 pass, 01 butterfly, 10 scaled butterfly, 11 swap (sampled with the beat)
//   in_valid_i   input beat present
//   in_ready_o   input beat accepted this cycle (combinational from out_ready_i)
//   in_a_i       LANES x WIDTH signed, lane i at [i*WIDTH +: WIDTH]
//   in_b_i       same packing as in_a_i
//   out_valid_o  output beat present
//   out_ready_i  downstream accepts the output beat
//   out_sum_o    LANES x (WIDTH+1) signed, lane i at [i*(WIDTH+1) +: WIDTH+1]
//   out_diff_o   same packing as out_sum_o
//   out_last_o   high with the final beat of each block

module dct_butterfly_stage #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned LANES     = 4,
    parameter int unsigned BLOCK_LEN = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         blk_clr_i,
    input  logic [1:0]                   mode_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [LANES*WIDTH-1:0]       in_a_i,
    input  logic [LANES*WIDTH-1:0]       in_b_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [LANES*(WIDTH+1)-1:0]   out_sum_o,
    output logic [LANES*(WIDTH+1)-1:0]   out_diff_o,
    output logic                         out_last_o
);

    localparam int unsigned OW   = WIDTH + 1;
    localparam int unsigned CntW = (BLOCK_LEN > 2) ? $clog2(BLOCK_LEN) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(BLOCK_LEN - 1);

    typedef enum logic [1:0] {
        ModePass   = 2'b00,
        ModeBfly   = 2'b01,
        ModeScaled = 2'b10,
        ModeSwap   = 2'b11
    } mode_e;

    // Pipeline state
    logic                     s1_valid_q, s1_valid_d;
    logic                     s2_valid_q, s2_valid_d;
    logic [LANES*WIDTH-1:0]   s1_a_q, s1_b_q;
    mode_e                    s1_mode_q;
    logic [LANES*OW-1:0]      sum_q, diff_q;
    logic [LANES*OW-1:0]      sum_d, diff_d;
    logic [CntW-1:0]          cnt_q, cnt_d;

    logic en1, en2, in_xfer, out_xfer, s2_load;

    // Flow control: each stage may advance when it is empty or its successor advances.
    assign en2      = !s2_valid_q || out_ready_i;
    assign en1      = !s1_valid_q || en2;
    assign in_ready_o = en1 && !blk_clr_i;
    assign in_xfer  = in_valid_i && in_ready_o;
    assign out_xfer = s2_valid_q && out_ready_i;
    // Data registers keep their values across a flush.
    assign s2_load  = en2 && s1_valid_q && !blk_clr_i;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        cnt_d      = cnt_q;
        if (blk_clr_i) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
            cnt_d      = '0;
        end else begin
            if (en1) begin
                s1_valid_d = in_xfer;
            end
            if (en2) begin
                s2_valid_d = s1_valid_q;
            end
            if (out_xfer) begin
                cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            cnt_q      <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_a_q    <= '0;
            s1_b_q    <= '0;
            s1_mode_q <= ModePass;
        end else if (in_xfer) begin
            s1_a_q    <= in_a_i;
            s1_b_q    <= in_b_i;
            s1_mode_q <= mode_e'(mode_i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= '0;
            diff_q <= '0;
        end else if (s2_load) begin
            sum_q  <= sum_d;
            diff_q <= diff_d;
        end
    end

    // Per-lane arithmetic; WIDTH+1 bits hold a+b and a-b exactly.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic signed [WIDTH:0] a_e, b_e, s, d, lane_s, lane_d;

        assign a_e = {s1_a_q[gi*WIDTH+WIDTH-1], s1_a_q[gi*WIDTH +: WIDTH]};
        assign b_e = {s1_b_q[gi*WIDTH+WIDTH-1], s1_b_q[gi*WIDTH +: WIDTH]};
        assign s   = a_e + b_e;
        assign d   = a_e - b_e;

        always_comb begin
            lane_s = s;
            lane_d = d;
            unique case (s1_mode_q)
                ModePass: begin
                    lane_s = a_e;
                    lane_d = b_e;
                end
                ModeBfly: begin
                    lane_s = s;
                    lane_d = d;
                end
                ModeScaled: begin
                    // Arithmetic shift: rounds toward -inf, result already sign-extended.
                    lane_s = s >>> 1;
                    lane_d = d >>> 1;
                end
                ModeSwap: begin
                    lane_s = b_e;
                    lane_d = a_e;
                end
                default: ;
            endcase
        end

        assign sum_d[gi*OW +: OW]  = lane_s;
        assign diff_d[gi*OW +: OW] = lane_d;
    end

    assign out_valid_o = s2_valid_q;
    assign out_sum_o   = sum_q;
    assign out_diff_o  = diff_q;
    assign out_last_o  = s2_valid_q && (cnt_q == CntMax);

endmodule
